// File: rtl/twitchcore_mem_arb.sv
// Arbitrates instruction fetch and data access onto one single-port memory with fixed MEM_LAT latency.
// Define TWITCHCORE_ARB_RR_EN for round-robin conflict resolution; the default gives data fixed priority.
module twitchcore_mem_arb #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [2:0] LAT   = 3'(MEM_LAT);
    localparam logic       OWN_I = 1'b0;
    localparam logic       OWN_D = 1'b1;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic       r_owner;
    logic       w_owner_nxt;
    logic       w_final;
    logic       w_accept;
    logic       w_pick_d;
    logic       w_grant_i;
    logic       w_grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_owner <= OWN_I;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // The last WAIT cycle delivers read data and may accept the next request at the same time.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_final     = (r_state == WAIT) && (r_cnt == LAT);
        w_accept    = !reset && !halt && ((r_state == IDLE) || w_final);
`ifdef TWITCHCORE_ARB_RR_EN
        // r_owner doubles as the last winner, so a conflict goes to the other port.
        w_pick_d    = d_req && (!i_req || (r_owner == OWN_I));
`else
        w_pick_d    = d_req;
`endif
        w_grant_d   = w_accept && w_pick_d;
        w_grant_i   = w_accept && i_req && !w_pick_d;
        if (w_grant_i || w_grant_d) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 3'd1;
            w_owner_nxt = w_grant_d ? OWN_D : OWN_I;
        end else if (w_final) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 3'd0;
        end else if (r_state == WAIT) begin
            w_cnt_nxt   = r_cnt + 3'd1;
        end
    end

    always_comb begin
        i_gnt    = w_grant_i;
        d_gnt    = w_grant_d;
        m_req    = w_grant_i || w_grant_d;
        m_we     = w_grant_d && d_we;
        m_be     = w_grant_d ? d_be : (w_grant_i ? 4'hF : 4'h0);
        m_addr   = w_grant_d ? d_addr : (w_grant_i ? i_addr : 32'h0);
        m_wdata  = w_grant_d ? d_wdata : 32'h0;
        i_rvalid = !reset && w_final && (r_owner == OWN_I);
        d_rvalid = !reset && w_final && (r_owner == OWN_D);
        i_rdata  = i_rvalid ? m_rdata : 32'h0;
        d_rdata  = d_rvalid ? m_rdata : 32'h0;
        busy     = !reset && (r_state == WAIT);
    end

endmodule
